// File: rtl/gyro_pkg.sv
// rtl/gyro_pkg.sv - shared constants and saturation helper for the gyro error demodulator
// Holds the FSM state codes, the 32-bit saturation limits, the default ADC width and sat32().
package gyro_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT_H = 3'd1;
    localparam logic [2:0] ACC_H  = 3'd2;
    localparam logic [2:0] WAIT_L = 3'd3;
    localparam logic [2:0] ACC_L  = 3'd4;

    localparam int ADC_BIT_DEF = 14;

    localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;
    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;

    function automatic logic signed [31:0] sat32(input logic signed [56:0] v);
        if (v > 57'(INT32_MAX)) return INT32_MAX;
        if (v < 57'(INT32_MIN)) return INT32_MIN;
        return v[31:0];
    endfunction

endpackage

// File: rtl/demod_half_timer.sv
// rtl/demod_half_timer.sv - half-period counter, freq/wait latches and modulation output
// Ports: i_clk/i_rst_n clock and async active-low reset; run_i keeps the counter running;
// load_i latches freq/wait; restart_i restarts the count at a half boundary; mod_d_i next o_mod;
// freq_i/wait_i raw settings; wait_zero_o latched wait is 0; load_wait_zero_o wait would latch as 0;
// wait_last_o last settling cycle; acc_last_o last cycle of the half; mod_o registered square wave.
module demod_half_timer #(
    parameter int CNT_BIT = 24
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               run_i,
    input  logic               load_i,
    input  logic               restart_i,
    input  logic               mod_d_i,
    input  logic [CNT_BIT-1:0] freq_i,
    input  logic [CNT_BIT-1:0] wait_i,
    output logic               wait_zero_o,
    output logic               load_wait_zero_o,
    output logic               wait_last_o,
    output logic               acc_last_o,
    output logic               mod_o
);

    logic [CNT_BIT-1:0] cnt_q;
    logic [CNT_BIT-1:0] freq_l_q;
    logic [CNT_BIT-1:0] wait_l_q;
    logic               mod_q;
    logic [CNT_BIT-1:0] freq_n;
    logic [CNT_BIT-1:0] wait_n;

    // Clamp so every half keeps at least one accumulated sample.
    always_comb begin
        freq_n = (freq_i < CNT_BIT'(2)) ? CNT_BIT'(2) : freq_i;
        wait_n = (wait_i > freq_n - CNT_BIT'(1)) ? freq_n - CNT_BIT'(1) : wait_i;
    end

    assign load_wait_zero_o = (wait_n == '0);
    assign wait_zero_o      = (wait_l_q == '0);
    // Only consulted while settling, where wait_l_q is at least 1.
    assign wait_last_o      = (cnt_q == wait_l_q - CNT_BIT'(1));
    assign acc_last_o       = (cnt_q == freq_l_q - CNT_BIT'(1));
    assign mod_o            = mod_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            freq_l_q <= '0;
            wait_l_q <= '0;
            mod_q    <= 1'b0;
        end else begin
            if (load_i) begin
                freq_l_q <= freq_n;
                wait_l_q <= wait_n;
            end
            cnt_q <= (!run_i || restart_i) ? '0 : cnt_q + CNT_BIT'(1);
            mod_q <= mod_d_i;
        end
    end

endmodule

// File: rtl/gyro_err_demod.sv
// rtl/gyro_err_demod.sv - square-wave modulation generator and synchronous error demodulator
// Ports: i_clk/i_rst_n clock and async active-low reset; i_en run enable; i_adc signed sample;
// i_freq half-period; i_wait_cnt settle samples; i_avg_sel log2 periods averaged; i_polarity negate;
// o_mod DAC modulation bit; o_err signed error word; o_err_vld update strobe; o_state FSM state.
module gyro_err_demod
    import gyro_pkg::*;
#(
    parameter int ADC_BIT = ADC_BIT_DEF,
    parameter int CNT_BIT = 24
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [ADC_BIT-1:0] i_adc,
    input  logic [CNT_BIT-1:0] i_freq,
    input  logic [CNT_BIT-1:0] i_wait_cnt,
    input  logic [2:0]         i_avg_sel,
    input  logic               i_polarity,
    output logic               o_mod,
    output logic [31:0]        o_err,
    output logic               o_err_vld,
    output logic [2:0]         o_state
);

    logic [2:0]         state_q, state_d;
    logic               load_d, restart_d;
    logic               wait_zero, load_wait_zero, wait_last, acc_last;
    logic               mod_d;

    logic signed [47:0] sum_h_q, sum_l_q;
    logic signed [55:0] acc_q;
    logic [7:0]         per_cnt_q;
    logic [2:0]         avg_l_q;
    logic signed [31:0] err_q;
    logic               vld_q;

    logic signed [47:0] adc_ext;
    logic signed [47:0] sum_l_fin;
    logic signed [55:0] acc_nxt;
    logic signed [55:0] acc_shr;
    logic signed [56:0] err_pre;
    logic [7:0]         per_nxt;
    logic               grp_done;

    demod_half_timer #(.CNT_BIT(CNT_BIT)) u_timer (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .run_i            (state_d != IDLE),
        .load_i           (load_d),
        .restart_i        (restart_d),
        .mod_d_i          (mod_d),
        .freq_i           (i_freq),
        .wait_i           (i_wait_cnt),
        .wait_zero_o      (wait_zero),
        .load_wait_zero_o (load_wait_zero),
        .wait_last_o      (wait_last),
        .acc_last_o       (acc_last),
        .mod_o            (o_mod)
    );

    // A zero settle window skips WAIT_x entirely, so half entries go straight to ACC_x.
    always_comb begin
        state_d   = state_q;
        load_d    = 1'b0;
        restart_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d   = load_wait_zero ? ACC_H : WAIT_H;
                load_d    = 1'b1;
                restart_d = 1'b1;
            end
            WAIT_H: if (wait_last) state_d = ACC_H;
            ACC_H: if (acc_last) begin
                state_d   = wait_zero ? ACC_L : WAIT_L;
                restart_d = 1'b1;
            end
            WAIT_L: if (wait_last) state_d = ACC_L;
            ACC_L: if (acc_last) begin
                state_d   = load_wait_zero ? ACC_H : WAIT_H;
                load_d    = 1'b1;
                restart_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (!i_en) begin
            state_d   = IDLE;
            load_d    = 1'b0;
            restart_d = 1'b0;
        end
        mod_d = (state_d == WAIT_H) || (state_d == ACC_H);
    end

    // Period close-out folds the final low sample in combinationally so the
    // error word lands one clock after the last sample.
    always_comb begin
        adc_ext   = 48'($signed(i_adc));
        sum_l_fin = sum_l_q + adc_ext;
        acc_nxt   = acc_q + 56'(sum_h_q) - 56'(sum_l_fin);
        per_nxt   = per_cnt_q + 8'd1;
        grp_done  = (per_nxt == (8'd1 << avg_l_q));
        acc_shr   = acc_nxt >>> avg_l_q;
        err_pre   = i_polarity ? -57'(acc_shr) : 57'(acc_shr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            sum_h_q   <= '0;
            sum_l_q   <= '0;
            acc_q     <= '0;
            per_cnt_q <= '0;
            avg_l_q   <= '0;
            err_q     <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= 1'b0;
            if (state_d == IDLE) begin
                sum_h_q   <= '0;
                sum_l_q   <= '0;
                acc_q     <= '0;
                per_cnt_q <= '0;
            end else begin
                if (state_q == ACC_H) sum_h_q <= sum_h_q + adc_ext;
                if (state_q == ACC_L) begin
                    if (acc_last) begin
                        sum_h_q <= '0;
                        sum_l_q <= '0;
                        if (grp_done) begin
                            err_q     <= sat32(err_pre);
                            vld_q     <= 1'b1;
                            acc_q     <= '0;
                            per_cnt_q <= '0;
                        end else begin
                            acc_q     <= acc_nxt;
                            per_cnt_q <= per_nxt;
                        end
                    end else begin
                        sum_l_q <= sum_l_fin;
                    end
                end
                // Averaging depth is fixed for a whole group.
                if (load_d && (state_q == IDLE || grp_done)) avg_l_q <= i_avg_sel;
            end
        end
    end

    assign o_err     = err_q;
    assign o_err_vld = vld_q;
    assign o_state   = state_q;

endmodule
